slave_burst_ctrl: RTL and testbench

//  Sequences one AXI-style slave transaction at a time through the shared burst address generator.

---
 rtl/bus_slave_pkg.sv | 41 ++++
 rtl/rr_arb2.sv | 31 +++
 rtl/slave_burst_ctrl.sv | 178 +++++++++++++++++
 tb/tb_slave_burst_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_pkg.sv
// Shared types for the AXI-style slave burst sequencer: burst/response codes,
// controller states and the arbiter grant encoding.
package bus_slave_pkg;

  localparam int ADDR_W = 12;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  // A beat wider than the peripheral, or the reserved burst code, turns the
  // whole burst into an error burst.
  function automatic logic desc_err(input logic [SIZE_W-1:0] size,
                                    input logic [1:0]        burst,
                                    input int                p_size);
    return (int'(size) > p_size) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the read and write address channels.
// The channel not served last wins a tie.
module rr_arb2
  import bus_slave_pkg::*;
(
  input  logic CLK,
  input  logic RESETn,
  input  logic en,
  input  logic req_rd,
  input  logic req_wr,
  input  logic accept,
  output logic grant_rd,
  output logic grant_wr
);

  grant_t last_grant_reg;

  always_comb begin
    grant_rd = en && req_rd && (!req_wr || (last_grant_reg == GRANT_WRITE));
    grant_wr = en && req_wr && !grant_rd;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_grant_reg <= GRANT_WRITE;
    end else if (accept) begin
      last_grant_reg <= grant_rd ? GRANT_READ : GRANT_WRITE;
    end
  end

endmodule

// File: rtl/slave_burst_ctrl.sv
// Sequences one AXI-style read or write burst at a time through an external
// address generator, driving memory strobes and the R/B response handshakes.
module slave_burst_ctrl
  import bus_slave_pkg::*;
#(
  parameter int P_SIZE = 4
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [SIZE_W-1:0] ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [SIZE_W-1:0] AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic              WLAST,
  output logic              RVALID,
  output logic              RLAST,
  input  logic              RREADY,
  output logic [1:0]        RRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic [ADDR_W-1:0] AG_ADDR,
  output logic [LEN_W-1:0]  AG_LEN,
  output logic [SIZE_W-1:0] AG_SIZE,
  output logic [1:0]        AG_BURST,
  output logic              AG_START,
  output logic              AG_NEXT,
  input  logic [ADDR_W-1:0] AG_ADDR_IN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  output logic              MEM_WE
);

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [LEN_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic               err_reg, err_next;
  logic               wlast_err_reg, wlast_err_next;

  logic grant_rd, grant_wr;
  logic ar_hs, aw_hs;
  logic last_beat;

  rr_arb2 u_arb (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .en       (state_reg == IDLE),
    .req_rd   (ARVALID),
    .req_wr   (AWVALID),
    .accept   (ar_hs || aw_hs),
    .grant_rd (grant_rd),
    .grant_wr (grant_wr)
  );

  // Grants already include the VALIDs, so READY equals the handshake.
  assign ARREADY = grant_rd;
  assign AWREADY = grant_wr;
  assign ar_hs   = grant_rd;
  assign aw_hs   = grant_wr;

  assign AG_ADDR  = grant_rd ? ARADDR  : AWADDR;
  assign AG_LEN   = grant_rd ? ARLEN   : AWLEN;
  assign AG_SIZE  = grant_rd ? ARSIZE  : AWSIZE;
  assign AG_BURST = grant_rd ? ARBURST : AWBURST;
  assign AG_START = ar_hs || aw_hs;

  assign MEM_ADDR  = AG_ADDR_IN;
  assign last_beat = (beat_cnt_reg == len_reg);

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    beat_cnt_next  = beat_cnt_reg;
    err_next       = err_reg;
    wlast_err_next = wlast_err_reg;
    MEM_RE         = 1'b0;
    MEM_WE         = 1'b0;
    AG_NEXT        = 1'b0;
    RVALID         = 1'b0;
    RLAST          = 1'b0;
    RRESP          = RESP_OKAY;
    WREADY         = 1'b0;
    BVALID         = 1'b0;
    BRESP          = RESP_OKAY;

    case (state_reg)
      IDLE: begin
        if (ar_hs) begin
          len_next       = ARLEN;
          err_next       = desc_err(ARSIZE, ARBURST, P_SIZE);
          beat_cnt_next  = '0;
          wlast_err_next = 1'b0;
          state_next     = RD_ISSUE;
        end else if (aw_hs) begin
          len_next       = AWLEN;
          err_next       = desc_err(AWSIZE, AWBURST, P_SIZE);
          beat_cnt_next  = '0;
          wlast_err_next = 1'b0;
          state_next     = WR_DATA;
        end
      end

      RD_ISSUE: begin
        MEM_RE     = !err_reg;
        state_next = RD_DATA;
      end

      RD_DATA: begin
        RVALID = 1'b1;
        RLAST  = last_beat;
        RRESP  = err_reg ? RESP_SLVERR : RESP_OKAY;
        if (RREADY) begin
          if (last_beat) begin
            state_next = IDLE;
          end else begin
            AG_NEXT       = 1'b1;
            beat_cnt_next = beat_cnt_reg + 8'd1;
            state_next    = RD_ISSUE;
          end
        end
      end

      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          MEM_WE = !err_reg;
          // WLAST is only audited; the beat count alone ends the burst.
          if (WLAST != last_beat) begin
            wlast_err_next = 1'b1;
          end
          if (last_beat) begin
            state_next = WR_RESP;
          end else begin
            AG_NEXT       = 1'b1;
            beat_cnt_next = beat_cnt_reg + 8'd1;
          end
        end
      end

      WR_RESP: begin
        BVALID = 1'b1;
        BRESP  = (err_reg || wlast_err_reg) ? RESP_SLVERR : RESP_OKAY;
        if (BREADY) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      beat_cnt_reg  <= '0;
      err_reg       <= 1'b0;
      wlast_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      beat_cnt_reg  <= beat_cnt_next;
      err_reg       <= err_next;
      wlast_err_reg <= wlast_err_next;
    end
  end

endmodule

// File: tb/tb_slave_burst_ctrl.sv
// Randomized self-checking bench for slave_burst_ctrl with a behavioural
// address generator and a closed-form burst address reference.
module tb_slave_burst_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        ARVALID = 1'b0, AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0;
  logic        RREADY = 1'b0, BREADY = 1'b0;
  logic [11:0] ARADDR = '0, AWADDR = '0;
  logic [7:0]  ARLEN = '0, AWLEN = '0;
  logic [2:0]  ARSIZE = '0, AWSIZE = '0;
  logic [1:0]  ARBURST = '0, AWBURST = '0;
  logic        ARREADY, AWREADY, WREADY, RVALID, RLAST, BVALID;
  logic [1:0]  RRESP, BRESP, AG_BURST;
  logic [11:0] AG_ADDR, AG_ADDR_IN, MEM_ADDR;
  logic [7:0]  AG_LEN;
  logic [2:0]  AG_SIZE;
  logic        AG_START, AG_NEXT, MEM_RE, MEM_WE;

  always #5 CLK = ~CLK;

  slave_burst_ctrl #(.P_SIZE(4)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY), .RRESP(RRESP),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .AG_ADDR(AG_ADDR), .AG_LEN(AG_LEN), .AG_SIZE(AG_SIZE), .AG_BURST(AG_BURST),
    .AG_START(AG_START), .AG_NEXT(AG_NEXT), .AG_ADDR_IN(AG_ADDR_IN),
    .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE)
  );

  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Closed-form address of beat i of a burst.
  function automatic logic [11:0] ref_addr(input int a, input int size, input int len,
                                           input int burst, input int i);
    int bytes, total, base;
    bytes = 1 << size;
    total = bytes * (len + 1);
    if (burst == 0) return 12'(a);
    if (burst == 1) return (i == 0) ? 12'(a) : 12'(((a / bytes) * bytes + i * bytes) % 4096);
    base = (a / total) * total;
    return 12'(base + ((a - base) + i * bytes) % total);
  endfunction

  // Behavioural address generator stepping one beat at a time.
  function automatic int wrap_total(input int size, input int len);
    return (1 << size) * (len + 1);
  endfunction

  function automatic logic [11:0] ag_step(input logic [11:0] cur, input int size, input int burst,
                                          input int base, input int total);
    int nx;
    nx = ((int'(cur) >> size) << size) + (1 << size);
    if (burst == 0) return cur;
    if (burst == 2 && nx >= base + total) return 12'(base);
    return 12'(nx);
  endfunction

  logic [11:0] ag_cur;
  int ag_size, ag_burst, ag_base, ag_total;
  assign AG_ADDR_IN = ag_cur;

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ag_cur <= '0;
    end else if (AG_START) begin
      ag_cur   <= AG_ADDR;
      ag_size  <= int'(AG_SIZE);
      ag_burst <= int'(AG_BURST);
      ag_total <= wrap_total(int'(AG_SIZE), int'(AG_LEN));
      ag_base  <= (int'(AG_ADDR) / wrap_total(int'(AG_SIZE), int'(AG_LEN))) *
                  wrap_total(int'(AG_SIZE), int'(AG_LEN));
    end else if (AG_NEXT) begin
      ag_cur <= ag_step(ag_cur, ag_size, ag_burst, ag_base, ag_total);
    end
  end

  // Strobe / pulse monitor, sampled mid-cycle.
  logic [11:0] rd_q[$];
  logic [11:0] wr_q[$];
  int next_cnt = 0, start_cnt = 0, excl_viol = 0;

  always @(negedge CLK) begin
    if (RESETn) begin
      if (MEM_RE) rd_q.push_back(MEM_ADDR);
      if (MEM_WE) wr_q.push_back(MEM_ADDR);
      if (AG_NEXT) next_cnt++;
      if (AG_START) start_cnt++;
      if ((AG_START && AG_NEXT) || (MEM_RE && MEM_WE)) excl_viol++;
    end
  end

  bit last_was_write = 1'b1;

  task automatic clear_mon();
    rd_q.delete();
    wr_q.delete();
    next_cnt  = 0;
    start_cnt = 0;
  endtask

  task automatic check_strobes(input bit is_rd, input int a, input int size, input int len,
                               input int burst, input bit err);
    int n;
    int exp_n;
    n = is_rd ? rd_q.size() : wr_q.size();
    exp_n = err ? 0 : len + 1;
    check_val(is_rd ? "rd_strobe_cnt" : "wr_strobe_cnt", n, exp_n);
    if (n == exp_n) begin
      for (int i = 0; i < n; i++)
        check_val(is_rd ? "rd_addr" : "wr_addr", is_rd ? rd_q[i] : wr_q[i],
                  ref_addr(a, size, len, burst, i));
    end
    check_val("ag_start_cnt", start_cnt, 1);
    check_val("ag_next_cnt", next_cnt, len);
  endtask

  // Tasks start and end at posedge+1; outputs are sampled at negedge.
  task automatic do_read(input int a, input int len, input int size, input int burst,
                         input bit tie, input int stall_beat, input int abort_beat);
    bit err, ok, seen;
    int b, stall, guard;
    err = (size > 4) || (burst == 3);
    clear_mon();
    ARADDR = 12'(a); ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    ARVALID = 1'b1;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 20) begin
      @(negedge CLK);
      if (tie && guard == 0) begin
        check_val("tie_arready", ARREADY, 1);
        check_val("tie_awready", AWREADY, 0);
      end
      ok = ARREADY;
      @(posedge CLK); #1;
      guard++;
    end
    ARVALID = 1'b0;
    last_was_write = 1'b0;
    check_val("ar_handshake", ok, 1);
    if (!ok) return;
    b = 0; guard = 0; seen = 1'b0;
    stall = (stall_beat >= 0) ? ((stall_beat == 0) ? 5 : 0) : $urandom_range(0, 2);
    while (b <= len && guard < 4000) begin
      if (b == abort_beat) begin
        #2 RESETn = 1'b0;
        #1;
        check_val("async_reset_outs",
                  {ARREADY, AWREADY, WREADY, RVALID, RLAST, BVALID, MEM_RE, MEM_WE,
                   AG_START, AG_NEXT, RRESP, BRESP}, 0);
        RREADY = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RESETn = 1'b1;
        last_was_write = 1'b1;
        return;
      end
      RREADY = (stall == 0);
      @(negedge CLK);
      if (RVALID) begin
        check_val("rlast", RLAST, (b == len));
        check_val("rresp", RRESP, err ? 2 : 0);
        if (!RREADY) begin
          stall--;
          seen = 1'b1;
          if (!err) check_val("rd_hold_addr", MEM_ADDR, ref_addr(a, size, len, burst, b));
        end else begin
          b++;
          seen = 1'b0;
          stall = (stall_beat >= 0) ? ((stall_beat == b) ? 5 : 0) : $urandom_range(0, 2);
        end
      end else if (seen) begin
        check_val("rvalid_hold", 0, 1);
        seen = 1'b0;
      end
      @(posedge CLK); #1;
      guard++;
    end
    RREADY = 1'b0;
    check_val("rd_beats", b, len + 1);
    check_strobes(1'b1, a, size, len, burst, err);
  endtask

  task automatic do_write(input int a, input int len, input int size, input int burst,
                          input bit tie, input int wlast_mode);
    bit err, ok, wl_err;
    int b, guard;
    err = (size > 4) || (burst == 3);
    clear_mon();
    AWADDR = 12'(a); AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    AWVALID = 1'b1;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 20) begin
      @(negedge CLK);
      if (tie && guard == 0) begin
        check_val("tie_awready", AWREADY, 1);
        check_val("tie_arready", ARREADY, 0);
      end
      ok = AWREADY;
      @(posedge CLK); #1;
      guard++;
    end
    AWVALID = 1'b0;
    last_was_write = 1'b1;
    check_val("aw_handshake", ok, 1);
    if (!ok) return;
    b = 0; guard = 0; wl_err = 1'b0;
    while (b <= len && guard < 4000) begin
      WVALID = ($urandom_range(0, 3) != 0);
      case (wlast_mode)
        0:       WLAST = (b == len);
        1:       WLAST = (b == 0);
        default: WLAST = (b == len) ^ ($urandom_range(0, 7) == 0);
      endcase
      @(negedge CLK);
      if (WVALID && WREADY) begin
        if (WLAST != (b == len)) wl_err = 1'b1;
        b++;
      end
      @(posedge CLK); #1;
      guard++;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check_val("wr_beats", b, len + 1);
    ok = 1'b0; guard = 0;
    while (!ok && guard < 60) begin
      BREADY = ($urandom_range(0, 1) == 1);
      @(negedge CLK);
      if (BVALID && BREADY) begin
        ok = 1'b1;
        check_val("bresp", BRESP, (err || wl_err) ? 2 : 0);
      end
      @(posedge CLK); #1;
      guard++;
    end
    BREADY = 1'b0;
    check_val("b_handshake", ok, 1);
    check_strobes(1'b0, a, size, len, burst, err);
  endtask

  // Both address channels valid at once; the reference arbitration decides order.
  task automatic run_pair(input int ra, input int rl, input int rs, input int rb,
                          input int wa, input int wl, input int ws, input int wb);
    ARADDR = 12'(ra); ARLEN = 8'(rl); ARSIZE = 3'(rs); ARBURST = 2'(rb); ARVALID = 1'b1;
    AWADDR = 12'(wa); AWLEN = 8'(wl); AWSIZE = 3'(ws); AWBURST = 2'(wb); AWVALID = 1'b1;
    if (last_was_write) begin
      do_read(ra, rl, rs, rb, 1'b1, -1, -1);
      do_write(wa, wl, ws, wb, 1'b0, 0);
    end else begin
      do_write(wa, wl, ws, wb, 1'b1, 0);
      do_read(ra, rl, rs, rb, 1'b0, -1, -1);
    end
  endtask

  task automatic rand_desc(output int a, output int len, output int size, output int burst);
    size  = $urandom_range(0, 5);
    burst = $urandom_range(0, 3);
    a     = $urandom_range(0, 4095);
    if (burst == 2) begin
      len = (1 << $urandom_range(1, 4)) - 1;
      a   = (a >> size) << size;
    end else begin
      len = $urandom_range(0, 15);
    end
  endtask

  initial begin
    int ra, rl, rs, rb, wa, wl, ws, wb;
    repeat (3) @(posedge CLK);
    #1 RESETn = 1'b1;
    @(negedge CLK);
    check_val("reset_outs",
              {ARREADY, AWREADY, WREADY, RVALID, RLAST, BVALID, MEM_RE, MEM_WE,
               AG_START, AG_NEXT, RRESP, BRESP}, 0);
    @(posedge CLK); #1;

    do_read(12'h100, 3, 4, 1, 1'b0, -1, -1);
    do_write(12'h134, 3, 2, 2, 1'b0, 0);
    run_pair(12'h040, 1, 2, 1, 12'h080, 2, 2, 1);
    run_pair(12'h0C0, 2, 3, 0, 12'h0E0, 1, 1, 2);
    do_read(12'h300, 3, 4, 1, 1'b0, 2, -1);
    do_write(12'h010, 1, 2, 1, 1'b0, 1);
    do_read(12'h020, 3, 5, 1, 1'b0, -1, -1);
    do_read(12'h200, 7, 4, 1, 1'b0, 0, 2);
    do_read(12'h280, 3, 3, 1, 1'b0, -1, -1);
    do_read(12'h000, 255, 0, 1, 1'b0, -1, -1);

    for (int t = 0; t < 30; t++) begin
      rand_desc(ra, rl, rs, rb);
      rand_desc(wa, wl, ws, wb);
      case ($urandom_range(0, 2))
        0:       do_read(ra, rl, rs, rb, 1'b0, -1, -1);
        1:       do_write(wa, wl, ws, wb, 1'b0, 2);
        default: run_pair(ra, rl, rs, rb, wa, wl, ws, wb);
      endcase
    end

    check_val("start_next_exclusive", excl_viol, 0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
